keypad_scanner: RTL and testbench



---
 rtl/keypad_pkg.sv | 68 ++++++
 rtl/keypad_debounce.sv | 56 +++++
 rtl/keypad_scanner.sv | 167 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x3 keypad scanner: scan states, key indices
// and the one-hot button codes understood by the LCD cursor/write controller.
package keypad_pkg;

  typedef enum logic [1:0] {COL0, COL1, COL2, EVAL} scan_state_e;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 3;
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

  // Row-major key index: row*3 + col
  localparam int KEY_1    = 0;
  localparam int KEY_2    = 1;
  localparam int KEY_3    = 2;
  localparam int KEY_4    = 3;
  localparam int KEY_5    = 4;
  localparam int KEY_6    = 5;
  localparam int KEY_7    = 6;
  localparam int KEY_8    = 7;
  localparam int KEY_9    = 8;
  localparam int KEY_STAR = 9;
  localparam int KEY_0    = 10;
  localparam int KEY_HASH = 11;

  localparam logic [9:0] NUM_1 = 10'b1000000000;
  localparam logic [9:0] NUM_2 = 10'b0100000000;
  localparam logic [9:0] NUM_3 = 10'b0010000000;
  localparam logic [9:0] NUM_4 = 10'b0001000000;
  localparam logic [9:0] NUM_5 = 10'b0000100000;
  localparam logic [9:0] NUM_6 = 10'b0000010000;
  localparam logic [9:0] NUM_7 = 10'b0000001000;
  localparam logic [9:0] NUM_8 = 10'b0000000100;
  localparam logic [9:0] NUM_9 = 10'b0000000010;
  localparam logic [9:0] NUM_0 = 10'b0000000001;

  localparam logic [1:0] CTRL_STAR = 2'b10;
  localparam logic [1:0] CTRL_HASH = 2'b01;

  typedef struct packed {
    logic [9:0] number;
    logic [1:0] control;
    logic       pressed;
  } key_out_t;

  // Anything other than exactly one key (idle or ghosting) decodes to all zeros.
  function automatic key_out_t decode_keys(input logic [NUM_KEYS-1:0] vec);
    key_out_t o;
    o = '0;
    case (vec)
      12'd1 << KEY_1:    o.number  = NUM_1;
      12'd1 << KEY_2:    o.number  = NUM_2;
      12'd1 << KEY_3:    o.number  = NUM_3;
      12'd1 << KEY_4:    o.number  = NUM_4;
      12'd1 << KEY_5:    o.number  = NUM_5;
      12'd1 << KEY_6:    o.number  = NUM_6;
      12'd1 << KEY_7:    o.number  = NUM_7;
      12'd1 << KEY_8:    o.number  = NUM_8;
      12'd1 << KEY_9:    o.number  = NUM_9;
      12'd1 << KEY_STAR: o.control = CTRL_STAR;
      12'd1 << KEY_0:    o.number  = NUM_0;
      12'd1 << KEY_HASH: o.control = CTRL_HASH;
      default: ;
    endcase
    o.pressed = (o.number != '0) || (o.control != '0);
    return o;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debouncer: a frame vector is committed once DEB_FRAMES
// consecutive scan frames (counting the previous one) agree.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEB_FRAMES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                eval,
  input  logic [NUM_KEYS-1:0] frame,
  output logic                commit,
  output logic [NUM_KEYS-1:0] committed
);

  localparam int CW = (DEB_FRAMES > 1) ? $clog2(DEB_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_FRAMES - 1);

  logic [CW-1:0]       match_cnt_q, match_cnt_d;
  logic [NUM_KEYS-1:0] prev_q, prev_d;
  logic [NUM_KEYS-1:0] committed_q, committed_d;

  always_comb begin
    match_cnt_d = match_cnt_q;
    prev_d      = prev_q;
    committed_d = committed_q;
    commit      = 1'b0;
    if (eval) begin
      prev_d = frame;
      if (frame != prev_q)
        match_cnt_d = '0;
      else if (match_cnt_q != CNT_MAX)
        match_cnt_d = match_cnt_q + 1'b1;
      // Saturated counter keeps re-committing the same vector, which is harmless.
      if (match_cnt_d == CNT_MAX) begin
        commit      = 1'b1;
        committed_d = frame;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_cnt_q <= '0;
      prev_q      <= '0;
      committed_q <= '0;
    end else begin
      match_cnt_q <= match_cnt_d;
      prev_q      <= prev_d;
      committed_q <= committed_d;
    end
  end

  assign committed = committed_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner feeding held button levels to the LCD controller.
// Define KEYPAD_REPEAT_EN for auto-repeat (one blank frame every REPEAT_FRAMES).
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV      = 4,
  parameter int DEB_FRAMES    = 4,
  parameter int REPEAT_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_row,
  output logic [2:0] key_col,
  output logic [9:0] number_btn,
  output logic [1:0] control_btn,
  output logic       key_pressed
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

  scan_state_e         state_q, state_d;
  logic [DW-1:0]       div_q, div_d;
  logic [2:0]          key_col_q, key_col_d;
  logic [NUM_KEYS-1:0] frame_q, frame_d;
  key_out_t            out_q, out_d;
  logic                sample, eval;
  logic                commit;
  logic [NUM_KEYS-1:0] committed;
  logic                chg;
  key_out_t            frm_dec;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    sample  = 1'b0;
    eval    = 1'b0;
    case (state_q)
      COL0, COL1, COL2: begin
        if (div_q == DIV_LAST) begin
          sample = 1'b1;
          div_d  = '0;
          case (state_q)
            COL0:    state_d = COL1;
            COL1:    state_d = COL2;
            default: state_d = EVAL;
          endcase
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: begin
        eval    = 1'b1;
        state_d = COL0;
      end
    endcase

    case (state_d)
      COL0:    key_col_d = 3'b001;
      COL1:    key_col_d = 3'b010;
      COL2:    key_col_d = 3'b100;
      default: key_col_d = 3'b000;
    endcase
  end

  // Rows are sampled once, at the end of each column slot, after they settle.
  always_comb begin
    frame_d = frame_q;
    if (sample) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        case (state_q)
          COL0:    frame_d[r*NUM_COLS + 0] = key_row[r];
          COL1:    frame_d[r*NUM_COLS + 1] = key_row[r];
          COL2:    frame_d[r*NUM_COLS + 2] = key_row[r];
          default: ;
        endcase
      end
    end
  end

  keypad_debounce #(
    .DEB_FRAMES(DEB_FRAMES)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .eval     (eval),
    .frame    (frame_q),
    .commit   (commit),
    .committed(committed)
  );

  assign chg     = commit && (frame_q != committed);
  assign frm_dec = decode_keys(frame_q);

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_FRAMES + 1);
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_FRAMES - 1);

  logic [RW-1:0] rpt_q, rpt_d;
  logic          blank_q, blank_d;
  key_out_t      cmt_dec;

  assign cmt_dec = decode_keys(committed);

  always_comb begin
    out_d   = out_q;
    rpt_d   = rpt_q;
    blank_d = blank_q;
    if (chg) begin
      out_d   = frm_dec;
      rpt_d   = '0;
      blank_d = 1'b0;
    end else if (eval) begin
      // The EVAL that ends the blank frame reasserts and does not count.
      if (blank_q) begin
        out_d   = cmt_dec;
        blank_d = 1'b0;
      end else if (cmt_dec.pressed) begin
        if (rpt_q == RPT_LAST) begin
          out_d   = '0;
          blank_d = 1'b1;
          rpt_d   = '0;
        end else begin
          rpt_d = rpt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rpt_q   <= '0;
      blank_q <= 1'b0;
    end else begin
      rpt_q   <= rpt_d;
      blank_q <= blank_d;
    end
  end
`else
  always_comb begin
    out_d = out_q;
    if (chg) out_d = frm_dec;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= COL0;
      div_q     <= '0;
      key_col_q <= 3'b001;
      frame_q   <= '0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      key_col_q <= key_col_d;
      frame_q   <= frame_d;
      out_q     <= out_d;
    end
  end

  assign key_col     = key_col_q;
  assign number_btn  = out_q.number;
  assign control_btn = out_q.control;
  assign key_pressed = out_q.pressed;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: directed test-plan steps plus random key activity,
// checked every cycle against a frame-level reference model of the keypad.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DF = 4;
  localparam int RF = 8;
  localparam int FL = 3*SD + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_row;
  logic [2:0] key_col;
  logic [9:0] number_btn;
  logic [1:0] control_btn;
  logic       key_pressed;

  logic [11:0] held;
  int n_chk  = 0;
  int n_fail = 0;

  // Model state: cycle phase within frame, frame being built, history, committed set
  int          ph;
  logic [11:0] m_frame, m_cmt;
  logic [11:0] hist[$];
  int          pos;
  logic [9:0]  e_num;
  logic [1:0]  e_ctl;
  logic        e_prs;

  always #5 clk = ~clk;

  // Physical keypad: a held key connects its column line to its row line.
  always_comb begin
    key_row = '0;
    for (int r = 0; r < 4; r++) key_row[r] = |(held[r*3 +: 3] & key_col);
  end

  keypad_scanner #(
    .SCAN_DIV     (SD),
    .DEB_FRAMES   (DF),
    .REPEAT_FRAMES(RF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_row    (key_row),
    .key_col    (key_col),
    .number_btn (number_btn),
    .control_btn(control_btn),
    .key_pressed(key_pressed)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ref_decode(input logic [11:0] v);
    int idx;
    e_num = '0; e_ctl = '0; e_prs = 1'b0;
    if ($countones(v) == 1) begin
      idx = 0;
      for (int i = 0; i < 12; i++) if (v[i]) idx = i;
      e_prs = 1'b1;
      if (idx == 9)       e_ctl = 2'b10;
      else if (idx == 11) e_ctl = 2'b01;
      else if (idx == 10) e_num = 10'd1;
      else                e_num = 10'd1 << (9 - idx);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    hist.push_back(12'd0);
    m_frame = '0; m_cmt = '0; pos = 0; ph = 0;
    ref_decode(12'd0);
  endtask

  task automatic model_eval();
    bit stable, show;
    hist.push_back(m_frame);
    if (hist.size() > DF) void'(hist.pop_front());
    stable = (hist.size() == DF);
    foreach (hist[i]) if (hist[i] != hist[0]) stable = 0;
    if (stable && m_frame != m_cmt) begin
      m_cmt = m_frame;
      pos   = 0;
    end else begin
      pos++;
    end
    show = 1;
`ifdef KEYPAD_REPEAT_EN
    if (pos > 0 && (pos % (RF + 1)) == RF) show = 0;
`endif
    if (show) ref_decode(m_cmt);
    else      ref_decode(12'd0);
  endtask

  // One clock: predict what the DUT does at this edge, then compare after it.
  task automatic tick();
    logic [2:0] e_col;
    if (ph < 3*SD && (ph % SD) == SD - 1) begin
      for (int r = 0; r < 4; r++) m_frame[r*3 + ph/SD] = held[r*3 + ph/SD];
    end else if (ph == 3*SD) begin
      model_eval();
    end
    @(posedge clk); #1;
    ph = (ph + 1) % FL;
    e_col = (ph == 3*SD) ? 3'b000 : (3'b001 << (ph / SD));
    check("col", {13'd0, key_col}, {13'd0, e_col});
    check("num", {6'd0, number_btn}, {6'd0, e_num});
    check("ctl", {14'd0, control_btn}, {14'd0, e_ctl});
    check("prs", {15'd0, key_pressed}, {15'd0, e_prs});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_col", {13'd0, key_col}, 16'h0001);
    check("rst_num", {6'd0, number_btn}, 16'h0000);
    check("rst_ctl", {14'd0, control_btn}, 16'h0000);
    check("rst_prs", {15'd0, key_pressed}, 16'h0000);
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    int lows, a, b, r, dur;
    rst  = 1'b0;
    held = '0;
    @(posedge clk); #1;
    do_reset();

    // '5' held from frame start: visible from cycle 52
    held = 12'd1 << 4;
    run(51);
    check("five_early", {6'd0, number_btn}, 16'h0000);
    tick();
    check("five_num", {6'd0, number_btn}, {6'd0, 10'b0000100000});
    check("five_prs", {15'd0, key_pressed}, 16'h0001);
    held = '0;
    run(51);
    check("five_hold", {15'd0, key_pressed}, 16'h0001);
    tick();
    check("five_rel_num", {6'd0, number_btn}, 16'h0000);
    check("five_rel_prs", {15'd0, key_pressed}, 16'h0000);

    // '3' bouncing every 7 cycles, then steady
    for (int t = 0; t < 100; t++) begin
      held = (((t / 7) % 2) == 0) ? (12'd1 << 2) : 12'd0;
      tick();
    end
    check("bounce_prs", {15'd0, key_pressed}, 16'h0000);
    held = 12'd1 << 2;
    run(6*FL);
    check("three_num", {6'd0, number_btn}, {6'd0, 10'b0010000000});

    // '1' and '2' together is ambiguous; then '1' alone
    held = 12'h003;
    run(6*FL);
    check("ghost_num", {6'd0, number_btn}, 16'h0000);
    check("ghost_prs", {15'd0, key_pressed}, 16'h0000);
    held = 12'h001;
    run(6*FL);
    check("one_num", {6'd0, number_btn}, {6'd0, 10'b1000000000});

    // '*' then '#'
    held = 12'd1 << 9;
    run(6*FL);
    check("star_ctl", {14'd0, control_btn}, 16'h0002);
    check("star_num", {6'd0, number_btn}, 16'h0000);
    held = 12'd1 << 11;
    run(6*FL);
    check("hash_ctl", {14'd0, control_btn}, 16'h0001);
    check("hash_num", {6'd0, number_btn}, 16'h0000);

    // '9' committed, reset in COL2, then re-debounce
    held = 12'd1 << 8;
    run(6*FL);
    check("nine_num", {6'd0, number_btn}, {6'd0, 10'b0000000010});
    while (ph != 2*SD + 1) tick();
    do_reset();
    run(51);
    check("nine_early", {6'd0, number_btn}, 16'h0000);
    tick();
    check("nine_again", {6'd0, number_btn}, {6'd0, 10'b0000000010});

    // '0' held: count blank frames over 27 frames sampled right after EVAL
    held = 12'd1 << 10;
    run(6*FL);
    while (ph != 0) tick();
    lows = 0;
    for (int f = 0; f < 27; f++) begin
      run(FL);
      if (number_btn[0] == 1'b0) lows++;
    end
`ifdef KEYPAD_REPEAT_EN
    check("zero_blanks", 16'(lows), 16'd3);
`else
    check("zero_blanks", 16'(lows), 16'd0);
`endif

    // Random activity: idle, single keys, key pairs, short glitches
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      a = $urandom_range(0, 11);
      b = $urandom_range(0, 11);
      if (r < 2)      held = '0;
      else if (r < 8) held = 12'd1 << a;
      else            held = (12'd1 << a) | (12'd1 << b);
      dur = ($urandom_range(0, 3) == 0) ? $urandom_range(1, FL - 1) : $urandom_range(FL, 6*FL);
      run(dur);
    end
    held = '0;
    run(5*FL);
    check("final_idle", {15'd0, key_pressed}, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
